// File: rtl/alu_seq_pkg.sv
// Shared encodings for the ALU sequencer: opcodes, command kinds and FSM states.
package alu_seq_pkg;

   localparam int unsigned DATA_W   = 4;
   localparam int unsigned SETTLE_W = 4;

   localparam logic [2:0] OP_NEGA = 3'b000;
   localparam logic [2:0] OP_NEGB = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;
   localparam logic [2:0] OP_AND  = 3'b100;
   localparam logic [2:0] OP_OR   = 3'b101;
   localparam logic [2:0] OP_MUL  = 3'b110;
   localparam logic [2:0] OP_XOR  = 3'b111;

   localparam logic [1:0] KIND_EXEC  = 2'b00;
   localparam logic [1:0] KIND_LOAD  = 2'b01;
   localparam logic [1:0] KIND_PEEK  = 2'b10;
   localparam logic [1:0] KIND_CLEAR = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_RESP  = 2'd2
   } state_e;

endpackage

// File: rtl/alu_sequencer_settle_counter.sv
// Settle down-counter: loads a start value, decrements to zero and holds there.
module settle_counter #(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/alu_sequencer.sv
// Command/response sequencer that drives a 4-bit combinational ALU, waits for it
// to settle, and returns the captured result with zero/negative flags.
module alu_sequencer
   import alu_seq_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 1,
   parameter int unsigned CNT_W         = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_kind,
   input  logic [2:0]        cmd_op,
   input  logic [DATA_W-1:0] cmd_operand,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [DATA_W-1:0] res_data,
   output logic              res_zero,
   output logic              res_neg,
   output logic [DATA_W-1:0] acc,
   output logic              busy,
   output logic [CNT_W-1:0]  ops_done,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic              alu_l,
   output logic              alu_m,
   output logic              alu_n,
   input  logic [DATA_W-1:0] alu_s
);

   localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);

   state_e              state_q;
   logic [1:0]          kind_q;
   logic [DATA_W-1:0]   acc_q;
   logic [DATA_W-1:0]   res_data_q;
   logic                res_valid_q;
   logic                res_zero_q;
   logic                res_neg_q;
   logic [CNT_W-1:0]    ops_q;
   logic [DATA_W-1:0]   alu_a_q;
   logic [DATA_W-1:0]   alu_b_q;
   logic [2:0]          alu_ctl_q;

   logic accept;
   logic is_alu_cmd;
   logic cnt_zero;

   // Ready also in RESP when the result is being consumed, so commands can stream.
   assign cmd_ready  = (state_q == ST_IDLE) || ((state_q == ST_RESP) && res_ready);
   assign accept     = cmd_valid && cmd_ready;
   assign is_alu_cmd = (cmd_kind == KIND_EXEC) || (cmd_kind == KIND_PEEK);

   settle_counter #(.W(SETTLE_W)) u_settle (
      .clk        (clk),
      .reset      (reset),
      .load_i     (accept && is_alu_cmd),
      .load_val_i (SETTLE_LOAD),
      .dec_i      (state_q == ST_DRIVE),
      .zero_o     (cnt_zero)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         kind_q      <= KIND_EXEC;
         acc_q       <= '0;
         res_data_q  <= '0;
         res_valid_q <= 1'b0;
         res_zero_q  <= 1'b0;
         res_neg_q   <= 1'b0;
         ops_q       <= '0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_ctl_q   <= '0;
      end else begin
         case (state_q)
            ST_DRIVE: begin
               if (cnt_zero) begin
                  res_data_q  <= alu_s;
                  res_zero_q  <= (alu_s == '0);
                  res_neg_q   <= alu_s[DATA_W-1];
                  res_valid_q <= 1'b1;
                  ops_q       <= ops_q + CNT_W'(1);
                  if (kind_q == KIND_EXEC) begin
                     acc_q <= alu_s;
                  end
                  state_q <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (res_ready) begin
                  res_valid_q <= 1'b0;
                  state_q     <= ST_IDLE;
               end
            end
            default: ;
         endcase

         // A new command overrides the RESP hand-back taken above on the same edge.
         if (accept) begin
            if (is_alu_cmd) begin
               alu_a_q   <= acc_q;
               alu_b_q   <= cmd_operand;
               alu_ctl_q <= cmd_op;
               kind_q    <= cmd_kind;
               state_q   <= ST_DRIVE;
            end else begin
               acc_q       <= (cmd_kind == KIND_LOAD) ? cmd_operand : '0;
               res_data_q  <= (cmd_kind == KIND_LOAD) ? cmd_operand : '0;
               res_zero_q  <= (cmd_kind == KIND_LOAD) ? (cmd_operand == '0) : 1'b1;
               res_neg_q   <= (cmd_kind == KIND_LOAD) ? cmd_operand[DATA_W-1] : 1'b0;
               res_valid_q <= 1'b1;
               kind_q      <= cmd_kind;
               state_q     <= ST_RESP;
            end
         end
      end
   end

   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;
   assign res_zero  = res_zero_q;
   assign res_neg   = res_neg_q;
   assign acc       = acc_q;
   assign busy      = (state_q != ST_IDLE);
   assign ops_done  = ops_q;
   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign alu_l     = alu_ctl_q[2];
   assign alu_m     = alu_ctl_q[1];
   assign alu_n     = alu_ctl_q[0];

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: instance 0 settles in 1 cycle, instance 1 in 3,
// each wired to a behavioural model of the 4-bit ALU.
module tb_alu_sequencer;
   import alu_seq_pkg::*;

   logic       clk = 1'b0;
   logic       reset     [2];
   logic       cmd_valid [2];
   logic       cmd_ready [2];
   logic [1:0] cmd_kind  [2];
   logic [2:0] cmd_op    [2];
   logic [3:0] cmd_operand [2];
   logic       res_valid [2];
   logic       res_ready [2];
   logic [3:0] res_data  [2];
   logic       res_zero  [2];
   logic       res_neg   [2];
   logic [3:0] acc       [2];
   logic       busy      [2];
   logic [7:0] ops_done  [2];
   logic [3:0] alu_a     [2];
   logic [3:0] alu_b     [2];
   logic       alu_l     [2];
   logic       alu_m     [2];
   logic       alu_n     [2];
   logic [3:0] alu_s     [2];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   function automatic logic [3:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
      case (op)
         OP_NEGA: return 4'(4'd0 - a);
         OP_NEGB: return 4'(4'd0 - b);
         OP_ADD:  return 4'(a + b);
         OP_SUB:  return 4'(a - b);
         OP_AND:  return a & b;
         OP_OR:   return a | b;
         OP_MUL:  return 4'(a * b);
         default: return a ^ b;
      endcase
   endfunction

   assign alu_s[0] = alu_f(alu_a[0], alu_b[0], {alu_l[0], alu_m[0], alu_n[0]});
   assign alu_s[1] = alu_f(alu_a[1], alu_b[1], {alu_l[1], alu_m[1], alu_n[1]});

   alu_sequencer #(.SETTLE_CYCLES(1), .CNT_W(8)) dut1 (
      .clk(clk), .reset(reset[0]), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
      .cmd_kind(cmd_kind[0]), .cmd_op(cmd_op[0]), .cmd_operand(cmd_operand[0]),
      .res_valid(res_valid[0]), .res_ready(res_ready[0]), .res_data(res_data[0]),
      .res_zero(res_zero[0]), .res_neg(res_neg[0]), .acc(acc[0]), .busy(busy[0]),
      .ops_done(ops_done[0]), .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_l(alu_l[0]),
      .alu_m(alu_m[0]), .alu_n(alu_n[0]), .alu_s(alu_s[0])
   );

   alu_sequencer #(.SETTLE_CYCLES(3), .CNT_W(8)) dut3 (
      .clk(clk), .reset(reset[1]), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
      .cmd_kind(cmd_kind[1]), .cmd_op(cmd_op[1]), .cmd_operand(cmd_operand[1]),
      .res_valid(res_valid[1]), .res_ready(res_ready[1]), .res_data(res_data[1]),
      .res_zero(res_zero[1]), .res_neg(res_neg[1]), .acc(acc[1]), .busy(busy[1]),
      .ops_done(ops_done[1]), .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_l(alu_l[1]),
      .alu_m(alu_m[1]), .alu_n(alu_n[1]), .alu_s(alu_s[1])
   );

   // Offer one command and return #1 after the edge that accepted it.
   task automatic send(input int u, input logic [1:0] k, input logic [2:0] op, input logic [3:0] v);
      int n = 0;
      @(negedge clk);
      cmd_valid[u] = 1'b1; cmd_kind[u] = k; cmd_op[u] = op; cmd_operand[u] = v;
      while (!cmd_ready[u] && n < 20) begin @(negedge clk); n++; end
      if (n >= 20) begin
         checks++; failures++;
         $display("FAIL send_timeout unit=%0d ready never seen", u);
      end
      @(posedge clk); #1;
      cmd_valid[u] = 1'b0;
   endtask

   // Count edges until res_valid rises; 20 means it never did.
   task automatic wait_res(input int u, output int n);
      n = 0;
      while (!res_valid[u] && n < 20) begin @(posedge clk); #1; n++; end
   endtask

   task automatic consume(input int u);
      @(negedge clk);
      res_ready[u] = 1'b1;
      @(posedge clk); #1;
      res_ready[u] = 1'b0;
   endtask

   task automatic test_reset();
      for (int u = 0; u < 2; u++) begin
         reset[u] = 1'b1; cmd_valid[u] = 1'b0; res_ready[u] = 1'b0;
         cmd_kind[u] = 2'b00; cmd_op[u] = 3'b000; cmd_operand[u] = 4'd0;
      end
      repeat (2) @(posedge clk);
      #1;
      checks++; if (res_valid[0] !== 1'b0) begin failures++; $display("FAIL reset_res_valid got=%0b exp=0", res_valid[0]); end
      checks++; if (acc[0] !== 4'd0) begin failures++; $display("FAIL reset_acc got=%0d exp=0", acc[0]); end
      checks++; if (ops_done[0] !== 8'd0) begin failures++; $display("FAIL reset_ops got=%0d exp=0", ops_done[0]); end
      checks++; if (busy[0] !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy[0]); end
      checks++; if (cmd_ready[0] !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready got=%0b exp=1", cmd_ready[0]); end
      @(negedge clk);
      reset[0] = 1'b0; reset[1] = 1'b0;
   endtask

   task automatic test_basic();
      int n;
      send(0, KIND_LOAD, 3'b000, 4'd5);
      checks++; if (res_valid[0] !== 1'b1 || res_data[0] !== 4'd5) begin failures++; $display("FAIL load5 valid=%0b data=%0d exp valid=1 data=5", res_valid[0], res_data[0]); end
      checks++; if (acc[0] !== 4'd5 || ops_done[0] !== 8'd0) begin failures++; $display("FAIL load5_acc acc=%0d ops=%0d exp acc=5 ops=0", acc[0], ops_done[0]); end
      consume(0);
      send(0, KIND_EXEC, OP_ADD, 4'd3);
      wait_res(0, n);
      checks++; if (n !== 1) begin failures++; $display("FAIL add_latency got=%0d exp=1", n); end
      checks++; if (res_data[0] !== 4'd8 || res_neg[0] !== 1'b1 || res_zero[0] !== 1'b0) begin failures++; $display("FAIL add_result data=%0d neg=%0b zero=%0b exp 8/1/0", res_data[0], res_neg[0], res_zero[0]); end
      checks++; if (acc[0] !== 4'd8 || ops_done[0] !== 8'd1) begin failures++; $display("FAIL add_acc acc=%0d ops=%0d exp acc=8 ops=1", acc[0], ops_done[0]); end
      consume(0);
      checks++; if (res_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin failures++; $display("FAIL consume valid=%0b busy=%0b exp 0/0", res_valid[0], busy[0]); end
      send(0, KIND_EXEC, OP_SUB, 4'd8);
      wait_res(0, n);
      checks++; if (res_data[0] !== 4'd0 || res_zero[0] !== 1'b1 || acc[0] !== 4'd0) begin failures++; $display("FAIL sub_result data=%0d zero=%0b acc=%0d exp 0/1/0", res_data[0], res_zero[0], acc[0]); end
      consume(0);
      send(0, KIND_LOAD, 3'b000, 4'd3);
      consume(0);
      send(0, KIND_EXEC, OP_MUL, 4'd5);
      wait_res(0, n);
      checks++; if (res_data[0] !== 4'd15 || acc[0] !== 4'd15 || ops_done[0] !== 8'd3) begin failures++; $display("FAIL mul_result data=%0d acc=%0d ops=%0d exp 15/15/3", res_data[0], acc[0], ops_done[0]); end
      consume(0);
   endtask

   task automatic test_peek();
      int n;
      send(0, KIND_LOAD, 3'b000, 4'd1);
      consume(0);
      send(0, KIND_PEEK, OP_NEGA, 4'd0);
      wait_res(0, n);
      checks++; if (n !== 1 || res_data[0] !== 4'd15 || res_neg[0] !== 1'b1) begin failures++; $display("FAIL peek_result lat=%0d data=%0d neg=%0b exp 1/15/1", n, res_data[0], res_neg[0]); end
      checks++; if (acc[0] !== 4'd1 || ops_done[0] !== 8'd4) begin failures++; $display("FAIL peek_acc acc=%0d ops=%0d exp acc=1 ops=4", acc[0], ops_done[0]); end
      consume(0);
      send(0, KIND_EXEC, OP_XOR, 4'd6);
      wait_res(0, n);
      checks++; if (res_data[0] !== 4'd7 || acc[0] !== 4'd7) begin failures++; $display("FAIL xor_result data=%0d acc=%0d exp 7/7", res_data[0], acc[0]); end
      consume(0);
   endtask

   task automatic test_stall();
      send(1, KIND_LOAD, 3'b000, 4'd4);
      checks++; if (res_valid[1] !== 1'b1 || acc[1] !== 4'd4) begin failures++; $display("FAIL s3_load valid=%0b acc=%0d exp 1/4", res_valid[1], acc[1]); end
      consume(1);
      send(1, KIND_EXEC, OP_OR, 4'd9);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (res_valid[1] !== 1'b0 || alu_a[1] !== 4'd4 || alu_b[1] !== 4'd9 ||
             {alu_l[1], alu_m[1], alu_n[1]} !== OP_OR || busy[1] !== 1'b1 || cmd_ready[1] !== 1'b0) begin
            failures++;
            $display("FAIL drive_hold cyc=%0d valid=%0b a=%0d b=%0d ctl=%0d busy=%0b rdy=%0b exp 0/4/9/5/1/0",
                     i, res_valid[1], alu_a[1], alu_b[1], {alu_l[1], alu_m[1], alu_n[1]}, busy[1], cmd_ready[1]);
         end
         @(posedge clk); #1;
      end
      checks++; if (res_valid[1] !== 1'b1 || res_data[1] !== 4'd13 || res_neg[1] !== 1'b1 || acc[1] !== 4'd13) begin failures++; $display("FAIL or_result valid=%0b data=%0d neg=%0b acc=%0d exp 1/13/1/13", res_valid[1], res_data[1], res_neg[1], acc[1]); end
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         checks++;
         if (res_valid[1] !== 1'b1 || res_data[1] !== 4'd13 || cmd_ready[1] !== 1'b0 || busy[1] !== 1'b1 || alu_a[1] !== 4'd4) begin
            failures++;
            $display("FAIL resp_hold cyc=%0d valid=%0b data=%0d rdy=%0b busy=%0b a=%0d exp 1/13/0/1/4",
                     i, res_valid[1], res_data[1], cmd_ready[1], busy[1], alu_a[1]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int n;
      @(negedge clk);
      res_ready[1] = 1'b1;
      cmd_valid[1] = 1'b1; cmd_kind[1] = KIND_LOAD; cmd_operand[1] = 4'd6;
      #1;
      checks++; if (cmd_ready[1] !== 1'b1) begin failures++; $display("FAIL b2b_ready got=%0b exp=1", cmd_ready[1]); end
      @(posedge clk); #1;
      checks++; if (res_valid[1] !== 1'b1 || res_data[1] !== 4'd6 || acc[1] !== 4'd6 || ops_done[1] !== 8'd1) begin failures++; $display("FAIL b2b_load valid=%0b data=%0d acc=%0d ops=%0d exp 1/6/6/1", res_valid[1], res_data[1], acc[1], ops_done[1]); end
      cmd_kind[1] = KIND_EXEC; cmd_op[1] = OP_AND; cmd_operand[1] = 4'd3;
      @(posedge clk); #1;
      cmd_valid[1] = 1'b0; res_ready[1] = 1'b0;
      checks++; if (res_valid[1] !== 1'b0 || busy[1] !== 1'b1 || alu_a[1] !== 4'd6 || alu_b[1] !== 4'd3) begin failures++; $display("FAIL b2b_exec valid=%0b busy=%0b a=%0d b=%0d exp 0/1/6/3", res_valid[1], busy[1], alu_a[1], alu_b[1]); end
      wait_res(1, n);
      checks++; if (n !== 3 || res_data[1] !== 4'd2 || acc[1] !== 4'd2 || ops_done[1] !== 8'd2) begin failures++; $display("FAIL b2b_result lat=%0d data=%0d acc=%0d ops=%0d exp 3/2/2/2", n, res_data[1], acc[1], ops_done[1]); end
      consume(1);
   endtask

   task automatic test_async_reset();
      send(1, KIND_EXEC, OP_ADD, 4'd1);
      @(posedge clk); #3;
      reset[1] = 1'b1;
      #1;
      checks++;
      if (res_valid[1] !== 1'b0 || acc[1] !== 4'd0 || alu_a[1] !== 4'd0 || alu_b[1] !== 4'd0 ||
          {alu_l[1], alu_m[1], alu_n[1]} !== 3'd0 || ops_done[1] !== 8'd0 || busy[1] !== 1'b0 || res_data[1] !== 4'd0) begin
         failures++;
         $display("FAIL async_reset valid=%0b acc=%0d a=%0d b=%0d ctl=%0d ops=%0d busy=%0b data=%0d exp all 0",
                  res_valid[1], acc[1], alu_a[1], alu_b[1], {alu_l[1], alu_m[1], alu_n[1]}, ops_done[1], busy[1], res_data[1]);
      end
      @(negedge clk);
      reset[1] = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      checks++; if (res_valid[1] !== 1'b0 || ops_done[1] !== 8'd0 || busy[1] !== 1'b0) begin failures++; $display("FAIL post_reset valid=%0b ops=%0d busy=%0b exp 0/0/0", res_valid[1], ops_done[1], busy[1]); end
   endtask

   task automatic test_wrap();
      int n;
      @(negedge clk); reset[0] = 1'b1;
      @(negedge clk); reset[0] = 1'b0;
      for (int i = 0; i < 256; i++) begin
         send(0, KIND_EXEC, OP_ADD, 4'd1);
         wait_res(0, n);
         consume(0);
         if (i == 254) begin
            checks++; if (ops_done[0] !== 8'd255) begin failures++; $display("FAIL ops_255 got=%0d exp=255", ops_done[0]); end
         end
      end
      checks++; if (ops_done[0] !== 8'd0 || acc[0] !== 4'd0) begin failures++; $display("FAIL ops_wrap ops=%0d acc=%0d exp 0/0", ops_done[0], acc[0]); end
      send(0, KIND_EXEC, OP_ADD, 4'd1);
      wait_res(0, n);
      consume(0);
      send(0, KIND_CLEAR, 3'b000, 4'd9);
      checks++; if (res_valid[0] !== 1'b1 || res_data[0] !== 4'd0 || res_zero[0] !== 1'b1 || acc[0] !== 4'd0 || ops_done[0] !== 8'd1) begin failures++; $display("FAIL clear valid=%0b data=%0d zero=%0b acc=%0d ops=%0d exp 1/0/1/0/1", res_valid[0], res_data[0], res_zero[0], acc[0], ops_done[0]); end
      consume(0);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_peek();
      test_stall();
      test_back_to_back();
      test_async_reset();
      test_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1);
   end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Sequencing controller for the 4-bit combinational ALU (8 ops, 3-bit L/M/N control).
- Accepts commands over a valid/ready handshake and keeps a 4-bit accumulator that is always the ALU A operand.
- Drives the ALU operands and control, waits a parameterised settle time, then captures the result.
- Presents the result and flags over a second valid/ready handshake.
- Sits between the system command source and the ALU instance. The ALU itself is unchanged.

Parameters:
- SETTLE_CYCLES, 1: cycles the ALU inputs are held stable before capture; legal range 1..15.
- CNT_W, 8: width of the completed-operation counter.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a clk edge
- cmd_kind  in  2  00 EXEC, 01 LOAD, 10 PEEK, 11 CLEAR
- cmd_op  in  3  ALU opcode {L,M,N}
- cmd_operand  in  4  B operand (EXEC/PEEK) or load value (LOAD)
- res_valid  out  1  result available
- res_ready  in  1  result consumed when res_valid && res_ready at an edge
- res_data  out  4  result value
- res_zero  out  1  res_data == 0
- res_neg  out  1  res_data[3]
- acc  out  4  accumulator
- busy  out  1  state != IDLE
- ops_done  out  CNT_W  count of completed EXEC/PEEK commands; wraps modulo 2^CNT_W
- alu_a  out  4  to ALU A; equals acc latched at accept
- alu_b  out  4  to ALU B
- alu_l, alu_m, alu_n  out  1 each  ALU control
- alu_s  in  4  ALU result

Behaviour:
- Reset (async, immediate): every output reg is 0. This covers acc, res_*, alu_*, ops_done and the settle counter. State = IDLE. Any in-flight command is dropped and no result is produced.
- Opcode map {L,M,N}: 000 -A, 001 -B, 010 A+B, 011 A-B, 100 AND, 101 OR, 110 MUL (low 4 bits), 111 XOR. All arithmetic is mod 16.
- States: IDLE, DRIVE, RESP.
- cmd_ready = (state==IDLE) || (state==RESP && res_ready). This path is combinational from res_ready, which allows back-to-back commands.
- Accept EXEC/PEEK:
  - Register alu_a=acc, alu_b=cmd_operand, {alu_l,alu_m,alu_n}=cmd_op, and latch the kind.
  - Load cnt=SETTLE_CYCLES-1 and go to DRIVE.
- DRIVE: alu_* are held constant.
  - If cnt!=0, decrement.
  - If cnt==0, at that edge: res_data<=alu_s, set the flags, res_valid<=1, ops_done++. If the kind is EXEC, also acc<=alu_s. Go to RESP.
  - Latency: accept at edge k gives res_valid high from edge k+SETTLE_CYCLES.
- Accept LOAD: acc<=cmd_operand and res_data<=cmd_operand. Go directly to RESP; res_valid is high from edge k+1. ops_done is unchanged.
- Accept CLEAR: as LOAD with value 0.
- alu_* hold their last values outside DRIVE.
- RESP:
  - res_data and the flags are stable while res_valid && !res_ready.
  - On a handshake with no new command, res_valid<=0 and go to IDLE.
  - On a handshake together with cmd accept, process the new command as from IDLE at the same edge. res_valid drops unless the new command is LOAD/CLEAR, in which case it stays 1 with the new data.
- The operand source for A is the acc value at the accept edge. A PEEK never modifies acc.
- cmd_* are ignored when cmd_ready=0.

Decomposition:
- Package alu_seq_pkg holds:
  - opcode localparams OP_NEGA..OP_XOR (000..111)
  - command-kind localparams KIND_EXEC/LOAD/PEEK/CLEAR
  - state encoding (IDLE=0, DRIVE=1, RESP=2)
- The settle down-counter is a natural single sub-module: settle_counter (load, dec, zero flag).
- The FSM and datapath registers stay in alu_sequencer.
- The bench instantiates the existing ALU and connects it to alu_*.

Test Plan:
- LOAD 5, then EXEC op=010 operand 3 (SETTLE_CYCLES=1) -> res_data=8, res_neg=1, res_zero=0, acc=8, res_valid exactly 1 edge after accept, ops_done=1.
- Following EXEC op=011 operand 8 -> res_data=0, res_zero=1, acc=0. Then LOAD 3 and EXEC op=110 operand 5 -> res_data=15, acc=15.
- LOAD 1, PEEK op=000 -> res_data=15 (-1), acc stays 1. Then EXEC op=111 operand 6 -> res_data=7.
- SETTLE_CYCLES=3, res_ready held low 4 cycles after res_valid -> alu_* stable 3 cycles, res_data stable, cmd_ready=0, busy=1. Then release res_ready with cmd_valid high -> new command accepted on the same edge.
- Assert reset asynchronously mid-DRIVE (SETTLE_CYCLES=3) -> all outputs 0 immediately, state IDLE, no res_valid afterwards, ops_done=0.
- 256 EXEC commands with CNT_W=8 -> ops_done wraps to 0. A CLEAR leaves ops_done unchanged and gives res_data=0, res_zero=1.
